// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// The block is permuted on the way in. An output register plus a skid register
// give full throughput while in_ready is still taken straight from a flop.
module shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_inv,
  output logic                busy
);

  localparam int unsigned W    = 32 * NB;
  localparam int unsigned ROWS = 4;

  // Reject unsupported block widths and tag widths at elaboration.
  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  // Row rotation amount: Nb = 8 skips offset 2 on the lower two rows.
  function automatic int unsigned row_off(input int unsigned r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [W-1:0] fwd_c;
  logic [W-1:0] inv_c;
  logic [W-1:0] shifted_c;

  // Static byte routing for both directions; byte (r,c) lives at W-1-8*(4c+r).
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int unsigned OFF   = row_off(r);
      localparam int unsigned SRC_F = (c + OFF) % NB;
      localparam int unsigned SRC_I = (c + NB - OFF) % NB;
      localparam int unsigned DST   = W - 1 - 8 * (4 * c + r);
      localparam int unsigned BIT_F = W - 1 - 8 * (4 * SRC_F + r);
      localparam int unsigned BIT_I = W - 1 - 8 * (4 * SRC_I + r);
      assign fwd_c[DST -: 8] = in_data[BIT_F -: 8];
      assign inv_c[DST -: 8] = in_data[BIT_I -: 8];
    end
  end

  // Per-block direction select.
  assign shifted_c = in_inv ? inv_c : fwd_c;

  logic             or_valid_q, or_valid_d;
  logic [W-1:0]     or_data_q,  or_data_d;
  logic [TAG_W-1:0] or_tag_q,   or_tag_d;
  logic             or_inv_q,   or_inv_d;
  logic             sk_valid_q, sk_valid_d;
  logic [W-1:0]     sk_data_q,  sk_data_d;
  logic [TAG_W-1:0] sk_tag_q,   sk_tag_d;
  logic             sk_inv_q,   sk_inv_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q,     busy_d;
  logic             accept_c;
  logic             or_free_c;

  // Next-state for the output/skid pair; skid drains first to keep FIFO order.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_tag_d   = or_tag_q;
    or_inv_d   = or_inv_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_tag_d   = sk_tag_q;
    sk_inv_d   = sk_inv_q;

    accept_c  = in_valid & in_ready_q;
    or_free_c = ~or_valid_q | out_ready;

    if (or_free_c) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        or_tag_d   = sk_tag_q;
        or_inv_d   = sk_inv_q;
        sk_valid_d = accept_c;
        if (accept_c) begin
          sk_data_d = shifted_c;
          sk_tag_d  = in_tag;
          sk_inv_d  = in_inv;
        end
      end else begin
        or_valid_d = accept_c;
        if (accept_c) begin
          or_data_d = shifted_c;
          or_tag_d  = in_tag;
          or_inv_d  = in_inv;
        end
      end
    end else if (accept_c) begin
      sk_valid_d = 1'b1;
      sk_data_d  = shifted_c;
      sk_tag_d   = in_tag;
      sk_inv_d   = in_inv;
    end

    in_ready_d = ~sk_valid_d;
    busy_d     = or_valid_d | sk_valid_d;
  end

  // State registers; reset discards any in-flight blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      or_inv_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_tag_q   <= '0;
      sk_inv_q   <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      or_inv_q   <= or_inv_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_tag_q   <= sk_tag_d;
      sk_inv_q   <= sk_inv_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_tag   = or_tag_q;
  assign out_inv   = or_inv_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: directed vectors on Nb=4/8 plus a random soak of
// Nb=4/6/8 instances, each with an accept-side scoreboard and output monitor.
module tb_shift_rows_pipe;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [NI];
  logic         in_inv    [NI];
  logic         out_ready [NI];
  logic         in_ready  [NI];
  logic         out_valid [NI];
  logic         out_inv   [NI];
  logic         busy      [NI];
  logic [255:0] in_data   [NI];
  logic [255:0] out_data  [NI];
  logic [7:0]   in_tag    [NI];
  logic [7:0]   out_tag   [NI];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [255:0] data;
    logic [7:0]   tag;
    logic         inv;
  } exp_t;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    check(nm, 256'(act), 256'(exp));
  endtask

  // Reference: rotate each row of a byte matrix by its Rijndael offset.
  function automatic logic [255:0] ref_perm(input logic [255:0] d, input logic inv, input int nb);
    logic [7:0]   st [4][8];
    int           offs [4];
    int           src;
    logic [255:0] o;
    o = '0;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
        o[32*nb-1-8*(4*c+r) -: 8] = st[r][src];
      end
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned NBG = (g == 0) ? 4 : (g == 1) ? 6 : 8;
    localparam int unsigned WG  = 32 * NBG;
    logic [WG-1:0] od;
    exp_t          exp_q [$];

    shift_rows_pipe #(.NB(NBG), .TAG_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g][WG-1:0]),
      .in_inv    (in_inv[g]),
      .in_tag    (in_tag[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (od),
      .out_tag   (out_tag[g]),
      .out_inv   (out_inv[g]),
      .busy      (busy[g])
    );
    assign out_data[g] = 256'(od);

    // Monitor: push on accept, pop and compare on transfer, check stall stability.
    initial begin : mon
      logic         held_v;
      logic [255:0] held_d;
      exp_t         e;
      exp_t         ne;
      held_v = 1'b0;
      held_d = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q.delete();
          held_v = 1'b0;
        end else begin
          if (held_v)
            check($sformatf("sb_stable_nb%0d", NBG), out_data[g], held_d);
          if (out_valid[g] && out_ready[g]) begin
            check_b($sformatf("sb_avail_nb%0d", NBG), exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check($sformatf("sb_data_nb%0d", NBG), out_data[g], e.data);
              check($sformatf("sb_tag_nb%0d", NBG), 256'({out_inv[g], out_tag[g]}),
                    256'({e.inv, e.tag}));
            end
          end
          held_v = out_valid[g] && !out_ready[g];
          held_d = out_data[g];
          if (in_valid[g] && in_ready[g]) begin
            ne.data = ref_perm(in_data[g], in_inv[g], int'(NBG));
            ne.tag  = in_tag[g];
            ne.inv  = in_inv[g];
            exp_q.push_back(ne);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_reset(input int g, input string nm);
    check({nm, "_flags"}, 256'({in_ready[g], out_valid[g], busy[g], out_inv[g], out_tag[g]}),
          256'(12'h800));
    check({nm, "_data"}, out_data[g], 256'd0);
  endtask

  localparam logic [127:0] AES_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] AES_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [255:0] SEQ32   =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin : main
    logic [255:0] v_in  [3];
    logic [255:0] v_out [3];
    logic         v_inv [3];
    logic [255:0] r;
    logic [255:0] held;
    int           acc;
    int           cyc;

    for (int g = 0; g < NI; g++) begin
      in_valid[g]  = 1'b0;
      in_inv[g]    = 1'b0;
      in_data[g]   = '0;
      in_tag[g]    = '0;
      out_ready[g] = 1'b1;
    end
    rst = 1'b1;
    in_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    for (int g = 0; g < NI; g++) chk_reset(g, $sformatf("reset%0d", g));
    tick();
    rst = 1'b0;

    // AES forward vector, 1-cycle latency, single-cycle valid.
    in_valid[0] = 1'b1;
    in_data[0]  = 256'(AES_IN);
    in_tag[0]   = 8'h01;
    in_inv[0]   = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    smp();
    check_b("fwd_valid", out_valid[0], 1'b1);
    check("fwd_data", out_data[0], 256'(AES_OUT));
    check("fwd_tag", 256'(out_tag[0]), 256'(8'h01));
    tick();
    smp();
    check_b("fwd_valid_drop", out_valid[0], 1'b0);

    // Back-to-back forward / inverse / forward.
    v_in  = '{256'(AES_IN), 256'(AES_OUT), 256'(AES_IN)};
    v_out = '{256'(AES_OUT), 256'(AES_IN), 256'(AES_OUT)};
    v_inv = '{1'b0, 1'b1, 1'b0};
    tick();
    in_valid[0] = 1'b1;
    in_data[0]  = v_in[0];
    in_inv[0]   = v_inv[0];
    in_tag[0]   = 8'h10;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        in_data[0] = v_in[i+1];
        in_inv[0]  = v_inv[i+1];
        in_tag[0]  = 8'(8'h11 + i);
      end else begin
        in_valid[0] = 1'b0;
      end
      smp();
      check_b($sformatf("b2b_valid%0d", i), out_valid[0], 1'b1);
      check($sformatf("b2b_data%0d", i), out_data[0], v_out[i]);
      check_b($sformatf("b2b_inv%0d", i), out_inv[0], v_inv[i]);
      tick();
    end

    // Nb = 8 forward and round trip.
    in_valid[2] = 1'b1;
    in_data[2]  = SEQ32;
    in_inv[2]   = 1'b0;
    in_tag[2]   = 8'h03;
    tick();
    in_valid[2] = 1'b0;
    smp();
    r = out_data[2];
    check("nb8_col0", 256'(r[255:224]), 256'(32'h00050e13));
    check("nb8_col7", 256'(r[31:0]), 256'(32'h1c010a0f));
    tick();
    in_valid[2] = 1'b1;
    in_data[2]  = r;
    in_inv[2]   = 1'b1;
    tick();
    in_valid[2] = 1'b0;
    smp();
    check("nb8_roundtrip", out_data[2], SEQ32);
    tick();

    // Backpressure: two accepted, third held off, in order release.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_tag[0]    = 8'd1;
    in_data[0]   = rand256();
    in_inv[0]    = 1'($urandom);
    tick();
    in_tag[0]  = 8'd2;
    in_data[0] = rand256();
    smp();
    check_b("bp_ready_1", in_ready[0], 1'b1);
    tick();
    in_tag[0]  = 8'd3;
    in_data[0] = rand256();
    smp();
    check_b("bp_ready_2", in_ready[0], 1'b0);
    check("bp_head_tag", 256'(out_tag[0]), 256'(8'd1));
    held = out_data[0];
    tick();
    smp();
    check_b("bp_ready_3", in_ready[0], 1'b0);
    check("bp_stable", out_data[0], held);
    tick();
    out_ready[0] = 1'b1;
    smp();
    check("bp_out1", 256'({out_valid[0], out_tag[0]}), 256'({1'b1, 8'd1}));
    check_b("bp_ready_4", in_ready[0], 1'b0);
    tick();
    smp();
    check_b("bp_ready_rise", in_ready[0], 1'b1);
    check("bp_out2", 256'({out_valid[0], out_tag[0]}), 256'({1'b1, 8'd2}));
    tick();
    in_valid[0] = 1'b0;
    smp();
    check("bp_out3", 256'({out_valid[0], out_tag[0]}), 256'({1'b1, 8'd3}));
    tick();
    smp();
    check_b("bp_empty", out_valid[0], 1'b0);
    tick();

    // Reset with both entries full and in_valid asserted.
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_tag[0]    = 8'd5;
    in_data[0]   = rand256();
    tick();
    in_tag[0] = 8'd6;
    tick();
    in_tag[0] = 8'd7;
    rst       = 1'b1;
    smp();
    check_b("rst_full", in_ready[0], 1'b0);
    tick();
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    smp();
    chk_reset(0, "rst_mid");
    tick();
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_tag[0]    = 8'd8;
    in_data[0]   = rand256();
    tick();
    in_valid[0] = 1'b0;
    smp();
    check("rst_after", 256'({out_valid[0], out_tag[0]}), 256'({1'b1, 8'd8}));
    tick();

    // Random soak across Nb = 4, 6, 8.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      for (int g = 0; g < NI; g++) begin
        in_valid[g]  = ($urandom_range(0, 3) != 0);
        out_ready[g] = ($urandom_range(0, 3) != 0);
        in_inv[g]    = 1'($urandom_range(0, 1));
        in_data[g]   = rand256();
        in_tag[g]    = 8'($urandom);
        if (in_valid[g] && in_ready[g]) acc++;
      end
      tick();
      cyc++;
    end
    check_b("soak_count", acc >= 10000, 1'b1);
    for (int g = 0; g < NI; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
    end
    repeat (4) tick();
    smp();
    for (int g = 0; g < NI; g++) check_b($sformatf("drain_busy%0d", g), busy[g], 1'b0);
    check("drain_q0", 256'(g_dut[0].exp_q.size()), 256'd0);
    check("drain_q1", 256'(g_dut[1].exp_q.size()), 256'd0);
    check("drain_q2", 256'(g_dut[2].exp_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows stage for the encrypt and decrypt datapaths.
- Supports block widths Nb = 4, 6 or 8 columns. Nb = 4 is the AES case.
- Direction is selected per transaction.
- Sits between SubBytes and MixColumns (encrypt), or between InvMixColumns and InvSubBytes (decrypt).
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven from a register and full throughput is kept.

Parameters:
- NB, 4, state columns. Legal values are 4, 6, 8; any other value is an elaboration error. Block width W = 32*NB.
- TAG_W, 8, width of the sideband tag carried alongside each block (round number, stream id). Minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input block valid
- in_ready  output  1  stage can accept a block. Driven directly from a register.
- in_data  input  W  input state
- in_inv  input  1  0 = ShiftRows (rotate left), 1 = InvShiftRows (rotate right)
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  output block valid
- out_ready  input  1  downstream accepts
- out_data  output  W  shifted state
- out_tag  output  TAG_W  tag belonging to out_data
- out_inv  output  1  in_inv belonging to out_data
- busy  output  1  at least one entry held (out_valid | skid_valid)

Behaviour:
- Byte map: state byte (r,c), r = 0..3, c = 0..NB-1, sits at bits [W-1-8*(4c+r) -: 8]. Column-major with byte 0 at the MSB.
- Row offsets:
  - NB = 4 or 6: off = {0,1,2,3}.
  - NB = 8: off = {0,1,3,4}.
- Forward: out(r,c) = in(r, (c+off_r) mod NB).
- Inverse: out(r,c) = in(r, (c-off_r+NB) mod NB).
- The permutation is applied combinationally on in_data at accept time. Registers store the already-shifted block together with its tag and inv bit.
- Accept condition: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Storage is an output register (OR) plus a skid register (SK). in_ready = !sk_valid.
- Per-cycle update, evaluated together:
  - OR empty, or OR transferring this cycle:
    - if SK is full, SK moves to OR;
    - otherwise an accepted input goes to OR.
    - If SK moves to OR and an input is accepted in the same cycle, that input goes into SK.
  - OR full and not transferring: an accepted input goes to SK.
- Ordering is strict FIFO. No block is dropped or duplicated.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 block per cycle while out_ready = 1.
- Stall behaviour: with out_ready held at 0, two blocks are accepted, then in_ready = 0.
  - in_ready rises on the cycle after the first output transfer.
- out_data, out_tag and out_inv are stable while out_valid = 1 and out_ready = 0.
- Reset (rst = 1 at a clock edge): or_valid = 0, sk_valid = 0, out_data = 0, out_tag = 0, out_inv = 0, in_ready = 1, busy = 0.
  - In-flight blocks are discarded. Reset overrides any accept or transfer in the same cycle.
- in_valid asserted during reset is ignored, and nothing is accepted on that edge.
- in_inv can change between consecutive blocks. Each block uses its own inv bit.
- No assumption is made on in_data when in_valid = 0. Registers hold their value while not loading.

Test Plan:
- NB = 4, forward:
  - Stimulus: in_data = d42711aee0bf98f1b8b45de51e415230, tag = 01, out_ready = 1.
  - Required: next cycle out_data = d4bf5d30e0b452aeb84111f11e2798e5, out_tag = 01, out_valid for exactly 1 cycle.
- NB = 4, inverse:
  - Stimulus: in_inv = 1, in_data = d4bf5d30e0b452aeb84111f11e2798e5.
  - Required: out_data = d42711aee0bf98f1b8b45de51e415230.
  - Also: back-to-back forward/inverse/forward blocks produce the matching three results on consecutive cycles.
- NB = 8, forward:
  - Stimulus: in_data bytes 00..1F in byte order.
  - Required: out column 0 = 00050e13, column 7 = 1c010a0f.
  - Also: feeding that result back with inv = 1 restores 00..1F.
- Backpressure:
  - Stimulus: out_ready = 0, stream of tags 1, 2, 3.
  - Required: tags 1 and 2 accepted; the cycle after the 2nd accept in_ready = 0 and tag 3 is held off.
  - Then raise out_ready: outputs are tags 1, 2, 3 in order; in_ready returns 1 the cycle after tag 1 transfers.
  - Also: out_data is stable throughout the stall.
- Reset mid-operation:
  - Stimulus: both entries full, then rst = 1 for 1 cycle with in_valid = 1.
  - Required: next cycle out_valid = 0, busy = 0, in_ready = 1, outputs zeroed; the first block after reset emerges with 1-cycle latency.
- Random soak:
  - Stimulus: 10k blocks, random in_valid / out_ready / in_inv, NB in {4, 6, 8}.
  - Required: scoreboard against a reference permutation; zero mismatches, loss or reordering.
